// File: rtl/qmul_pkg.sv
// Shared types and widths for the sequential quaternion multiplier.
package qmul_pkg;

  localparam int OPW        = 16;  // operand component width (unsigned)
  localparam int HW         = 19;  // Hadamard-transformed operand width (signed)
  localparam int PW         = 38;  // multiplier product width (signed)
  localparam int SW         = 40;  // Hadamard transform of the products (signed)
  localparam int CW         = 37;  // result component width (signed)
  localparam int MUL_CYCLES = 8;
  localparam int KW         = $clog2(MUL_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    COMB,
    DONE
  } state_e;

  // Zero-extend an unsigned operand component into a signed multiplier input.
  function automatic logic signed [HW-1:0] zext_op(input logic [OPW-1:0] x);
    return signed'({{(HW-OPW){1'b0}}, x});
  endfunction

endpackage

// File: rtl/qmul_h4.sv
// Four-point Hadamard transform of a signed vector; grows two bits so no sum truncates.
module qmul_h4 #(
  parameter int IW = 17,
  parameter int OW = IW + 2
) (
  input  logic signed [IW-1:0] x0_i,
  input  logic signed [IW-1:0] x1_i,
  input  logic signed [IW-1:0] x2_i,
  input  logic signed [IW-1:0] x3_i,
  output logic signed [OW-1:0] h0_o,
  output logic signed [OW-1:0] h1_o,
  output logic signed [OW-1:0] h2_o,
  output logic signed [OW-1:0] h3_o
);

  logic signed [OW-1:0] x0_e, x1_e, x2_e, x3_e;
  logic signed [OW-1:0] sum02, sum13, dif02, dif13;

  assign x0_e = {{(OW-IW){x0_i[IW-1]}}, x0_i};
  assign x1_e = {{(OW-IW){x1_i[IW-1]}}, x1_i};
  assign x2_e = {{(OW-IW){x2_i[IW-1]}}, x2_i};
  assign x3_e = {{(OW-IW){x3_i[IW-1]}}, x3_i};

  // Butterfly: shared partial sums/differences, then the four outputs.
  assign sum02 = x0_e + x2_e;
  assign sum13 = x1_e + x3_e;
  assign dif02 = x0_e - x2_e;
  assign dif13 = x1_e - x3_e;

  assign h0_o = sum02 + sum13;
  assign h1_o = sum02 - sum13;
  assign h2_o = dif02 + dif13;
  assign h3_o = dif02 - dif13;

endmodule

// File: rtl/qmul_seq.sv
// Sequential quaternion multiplier: eight products on one shared 19x19 multiplier,
// recombined through Hadamard transforms. Result appears 10 cycles after accept.
module qmul_seq
  import qmul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OPW-1:0]        a0,
  input  logic [OPW-1:0]        a1,
  input  logic [OPW-1:0]        a2,
  input  logic [OPW-1:0]        a3,
  input  logic [OPW-1:0]        b0,
  input  logic [OPW-1:0]        b1,
  input  logic [OPW-1:0]        b2,
  input  logic [OPW-1:0]        b3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [CW-1:0]  c0,
  output logic signed [CW-1:0]  c1,
  output logic signed [CW-1:0]  c2,
  output logic signed [CW-1:0]  c3,
  output logic                  busy
);

  state_e               state_q;
  logic [KW-1:0]        k_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 comb_ph_q;   // COMB takes two cycles: 0 = register s, 1 = register c
  logic                 accept;

  logic [OPW-1:0]       a_q [4];
  logic [OPW-1:0]       b_q [4];
  logic signed [HW-1:0] p_h [4];
  logic signed [HW-1:0] q_h [4];
  logic signed [HW-1:0] p_q [4];
  logic signed [HW-1:0] q_q [4];
  logic signed [PW-1:0] r_q [4];
  logic signed [PW-1:0] o_q [4];
  logic signed [SW-1:0] s_h [4];
  logic signed [SW-1:0] s_q [4];
  logic signed [SW-1:0] t_v [4];
  logic signed [SW-1:0] o2_v [4];
  logic signed [CW-1:0] c_d [4];
  logic signed [CW-1:0] c_q [4];

  logic signed [HW-1:0] mul_a, mul_b;
  logic signed [PW-1:0] prod;

  assign accept = (state_q == IDLE) && in_ready_q && in_valid;

  qmul_h4 #(.IW(OPW+1), .OW(HW)) u_h_a (
    .x0_i({1'b0, a0}), .x1_i({1'b0, a1}), .x2_i({1'b0, a2}), .x3_i({1'b0, a3}),
    .h0_o(p_h[0]),     .h1_o(p_h[1]),     .h2_o(p_h[2]),     .h3_o(p_h[3])
  );

  qmul_h4 #(.IW(OPW+1), .OW(HW)) u_h_b (
    .x0_i({1'b0, b0}), .x1_i({1'b0, b1}), .x2_i({1'b0, b2}), .x3_i({1'b0, b3}),
    .h0_o(q_h[0]),     .h1_o(q_h[1]),     .h2_o(q_h[2]),     .h3_o(q_h[3])
  );

  qmul_h4 #(.IW(PW), .OW(SW)) u_h_r (
    .x0_i(r_q[0]), .x1_i(r_q[1]), .x2_i(r_q[2]), .x3_i(r_q[3]),
    .h0_o(s_h[0]), .h1_o(s_h[1]), .h2_o(s_h[2]), .h3_o(s_h[3])
  );

  // Multiplier operand select: k=0..3 transformed pairs, k=4..7 cross terms.
  always_comb begin
    // NOTE: defaults first so every path assigns mul_a/mul_b and no latch is inferred.
    mul_a = '0;
    mul_b = '0;
    if (!k_q[2]) begin
      mul_a = p_q[k_q[1:0]];
      mul_b = q_q[k_q[1:0]];
    end else begin
      case (k_q[1:0])
        2'd0:    begin mul_a = zext_op(a_q[0]); mul_b = zext_op(b_q[0]); end
        2'd1:    begin mul_a = zext_op(b_q[2]); mul_b = zext_op(a_q[3]); end
        2'd2:    begin mul_a = zext_op(b_q[3]); mul_b = zext_op(a_q[1]); end
        default: begin mul_a = zext_op(b_q[1]); mul_b = zext_op(a_q[2]); end
      endcase
    end
  end

  assign prod = PW'(mul_a) * PW'(mul_b);

  // Recombination: t = s/4 (exact, s is a multiple of 4), o terms doubled.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      t_v[i]  = s_q[i] >>> 2;
      o2_v[i] = {o_q[i][PW-1], o_q[i], 1'b0};
    end
    c_d[0] = CW'(o2_v[0] - t_v[0]);
    c_d[1] = CW'(t_v[1] - o2_v[1]);
    c_d[2] = CW'(t_v[2] - o2_v[2]);
    c_d[3] = CW'(t_v[3] - o2_v[3]);
  end

  // Datapath capture: operands on accept, one product per MUL cycle, s in first COMB cycle.
  // NOTE: datapath registers carry no reset; each is written before the FSM lets it be read.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= '{a0, a1, a2, a3};
      b_q <= '{b0, b1, b2, b3};
      p_q <= p_h;
      q_q <= q_h;
    end
    if (state_q == MUL) begin
      if (!k_q[2]) r_q[k_q[1:0]] <= prod;
      else         o_q[k_q[1:0]] <= prod;
    end
    if (state_q == COMB && !comb_ph_q) begin
      s_q <= s_h;
    end
  end

  // Control FSM with registered handshake outputs and result registers.
  // NOTE: non-blocking assignments throughout so every branch sees pre-edge state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      comb_ph_q   <= 1'b0;
      for (int i = 0; i < 4; i++) c_q[i] <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q    <= MUL;
            k_q        <= '0;
            in_ready_q <= 1'b0;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        MUL: begin
          k_q <= k_q + 1'b1;
          if (k_q == KW'(MUL_CYCLES - 1)) begin
            state_q   <= COMB;
            comb_ph_q <= 1'b0;
          end
        end
        COMB: begin
          if (!comb_ph_q) begin
            comb_ph_q <= 1'b1;
          end else begin
            comb_ph_q   <= 1'b0;
            c_q         <= c_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign c0        = c_q[0];
  assign c1        = c_q[1];
  assign c2        = c_q[2];
  assign c3        = c_q[3];

endmodule

// File: tb/tb_qmul_seq.sv
// Scoreboard bench for qmul_seq: reference is the direct quaternion product formula.
module tb_qmul_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready;
  logic [15:0]        a0, a1, a2, a3, b0, b1, b2, b3;
  logic               out_valid, out_ready;
  logic signed [36:0] c0, c1, c2, c3;
  logic               busy;
  logic signed [36:0] c_obs [4];

  typedef longint quat_t [4];
  typedef struct { longint c [4]; } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  assign c_obs[0] = c0;
  assign c_obs[1] = c1;
  assign c_obs[2] = c2;
  assign c_obs[3] = c3;

  qmul_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .out_valid(out_valid), .out_ready(out_ready),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3),
    .busy(busy)
  );

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic exp_t qmul_ref(input quat_t a, input quat_t b);
    exp_t r;
    r.c[0] = a[0]*b[0] - a[1]*b[1] - a[2]*b[2] - a[3]*b[3];
    r.c[1] = a[0]*b[1] + a[1]*b[0] + a[2]*b[3] - a[3]*b[2];
    r.c[2] = a[0]*b[2] - a[1]*b[3] + a[2]*b[0] + a[3]*b[1];
    r.c[3] = a[0]*b[3] + a[1]*b[2] - a[2]*b[1] + a[3]*b[0];
    return r;
  endfunction

  task automatic drive_ops(input quat_t qa, input quat_t qb);
    a0 = 16'(qa[0]); a1 = 16'(qa[1]); a2 = 16'(qa[2]); a3 = 16'(qa[3]);
    b0 = 16'(qb[0]); b1 = 16'(qb[1]); b2 = 16'(qb[2]); b3 = 16'(qb[3]);
  endtask

  task automatic drive_junk();
    a0 = 16'($urandom); a1 = 16'($urandom); a2 = 16'($urandom); a3 = 16'($urandom);
    b0 = 16'($urandom); b1 = 16'($urandom); b2 = 16'($urandom); b3 = 16'($urandom);
  endtask

  // One full transaction; 'stall' cycles of out_ready low once the result is up.
  task automatic run_op(input string name, input quat_t qa, input quat_t qb, input int stall);
    int   waited;
    int   lat;
    exp_t e;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check({name, "_in_ready_timeout"}, 0, 1);
      return;
    end
    drive_ops(qa, qb);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    sb.push_back(qmul_ref(qa, qb));
    #1;
    check({name, "_busy_after_accept"}, busy, 1);
    check({name, "_in_ready_after_accept"}, in_ready, 0);
    // Inputs must be ignored while busy; out_ready ignored outside DONE.
    drive_junk();
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 20);
    check({name, "_latency"}, lat, 10);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) check($sformatf("%s_c%0d", name, i), c_obs[i], e.c[i]);
    if (out_valid) begin
      if (stall > 0) begin
        for (int n = 0; n < stall; n++) begin
          @(negedge clk);
          check($sformatf("%s_hold%0d_valid", name, n), out_valid, 1);
          check($sformatf("%s_hold%0d_in_ready", name, n), in_ready, 0);
          for (int i = 0; i < 4; i++)
            check($sformatf("%s_hold%0d_c%0d", name, n, i), c_obs[i], e.c[i]);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check({name, "_valid_after_hs"}, out_valid, 0);
      check({name, "_busy_after_hs"}, busy, 0);
      check({name, "_in_ready_after_hs"}, in_ready, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    quat_t qa, qb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive_ops('{0, 0, 0, 0}, '{0, 0, 0, 0});
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_c0", c0, 0);
    check("rst_c3", c3, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", in_ready, 1);

    run_op("identity", '{1, 0, 0, 0}, '{5, 6, 7, 8}, 0);
    run_op("i_times_i", '{0, 1, 0, 0}, '{0, 1, 0, 0}, 0);
    run_op("i_times_j", '{0, 1, 0, 0}, '{0, 0, 1, 0}, 1);
    run_op("full_scale_bp", '{65535, 65535, 65535, 65535}, '{65535, 65535, 65535, 65535}, 5);
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) begin
        qa[i] = longint'($urandom_range(0, 65535));
        qb[i] = longint'($urandom_range(0, 65535));
      end
      run_op($sformatf("rand%0d", n), qa, qb, int'($urandom_range(0, 2)));
    end
    run_op("full_scale", '{65535, 65535, 65535, 65535}, '{65535, 65535, 65535, 65535}, 0);

    // Reset at k=3 of MUL: outputs clear at once, no result is produced.
    @(negedge clk);
    drive_ops('{1, 0, 0, 0}, '{5, 6, 7, 8});
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_c0", c0, 0);
    check("abort_c1", c1, 0);
    check("abort_c2", c2, 0);
    check("abort_c3", c3, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_release_in_ready", in_ready, 1);
    check("abort_release_busy", busy, 0);
    run_op("identity_after_abort", '{1, 0, 0, 0}, '{5, 6, 7, 8}, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
